// File: rtl/ift_mem_responder.sv
// rtl/ift_mem_responder.sv - taint-tracking fixed-latency memory responder; optional taint plane: IFT_MEM_RESPONDER_TAINT_EN
module ift_mem_responder #(
  parameter int          Width        = 32,
  parameter int          Depth        = 1024,
  parameter logic [31:0] BaseAddr     = 32'h8000_0000,
  parameter int          Latency      = 2,
  parameter int          GntGapCycles = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [31:0]      addr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [3:0]       strb_i,
  output logic             gnt_o,
  output logic             rvalid_o,
  output logic [Width-1:0] rdata_o,
  output logic             err_o,
  input  logic             req_i_t0,
  input  logic             we_i_t0,
  input  logic [31:0]      addr_i_t0,
  input  logic [Width-1:0] wdata_i_t0,
  input  logic [3:0]       strb_i_t0,
  output logic [Width-1:0] rdata_o_t0,
  output logic             rvalid_o_t0,
  output logic             gnt_o_t0
);

  localparam int          AW   = $clog2(Depth);
  localparam logic [31:0] SPAN = 32'(Depth * 4);

  typedef enum logic {ST_READY, ST_GAP} gnt_state_t;

  gnt_state_t state_q, state_d;
  logic [2:0] gap_q, gap_d;
  logic       gnt;
  logic       accept;

  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx;

  logic [Width-1:0] mem [Depth] = '{default: '0};
  logic [Width-1:0] rd_taint;

  logic             new_valid;
  logic             new_err;
  logic [Width-1:0] new_data;
  logic [Width-1:0] new_taint;

  logic             pv [Latency];
  logic             pe [Latency];
  logic [Width-1:0] pd [Latency];
  logic [Width-1:0] pt [Latency];

  assign offset   = addr_i - BaseAddr;
  assign in_range = (offset < SPAN);
  assign idx      = offset[AW+1:2];
  assign gnt_o    = gnt;
  assign accept   = req_i & gnt;

  // Grant throttle state register; reset clears the gap counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_READY;
      gap_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Grant throttle next state: hold grant low for GntGapCycles after each acceptance.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    gnt     = 1'b0;
    case (state_q)
      ST_READY: begin
        gnt = 1'b1;
        if (req_i && (GntGapCycles > 0)) begin
          state_d = ST_GAP;
          gap_d   = 3'(GntGapCycles);
        end
      end
      ST_GAP: begin
        gap_d = gap_q - 3'd1;
        if (gap_q <= 3'd1) begin
          state_d = ST_READY;
          gap_d   = 3'd0;
        end
      end
      default: begin
        state_d = ST_READY;
        gap_d   = 3'd0;
      end
    endcase
  end

  // Data array: byte-enabled writes commit at the acceptance edge; reset leaves contents alone.
  always_ff @(posedge clk_i) begin
    if (accept && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

`ifdef IFT_MEM_RESPONDER_TAINT_EN
  logic [Width-1:0] tmem [Depth] = '{default: '0};
  logic             ctl_t;

  assign ctl_t    = (|addr_i_t0) | we_i_t0 | req_i_t0;
  assign rd_taint = in_range ? (tmem[idx] | {Width{ctl_t}}) : {Width{ctl_t}};

  // Taint plane: written bytes take data taint plus control-path taint.
  always_ff @(posedge clk_i) begin
    if (accept && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_i[b]) tmem[idx][8*b +: 8] <= wdata_i_t0[8*b +: 8] | {8{ctl_t | strb_i_t0[b]}};
      end
    end
  end
`else
  logic unused_t0;

  assign unused_t0 = ^{req_i_t0, we_i_t0, addr_i_t0, wdata_i_t0, strb_i_t0};
  assign rd_taint  = '0;
`endif

  assign new_valid = accept;
  assign new_err   = accept & ~in_range;
  assign new_data  = (accept && !we_i && in_range) ? mem[idx] : '0;
  assign new_taint = (accept && !we_i) ? rd_taint : '0;

  // Response pipeline: fixed depth, advances every cycle, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Latency; i++) begin
        pv[i] <= 1'b0;
        pe[i] <= 1'b0;
        pd[i] <= '0;
        pt[i] <= '0;
      end
    end else begin
      pv[0] <= new_valid;
      pe[0] <= new_err;
      pd[0] <= new_data;
      pt[0] <= new_taint;
      for (int i = 1; i < Latency; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
        pt[i] <= pt[i-1];
      end
    end
  end

  assign rvalid_o    = pv[Latency-1];
  assign err_o       = pe[Latency-1];
  assign rdata_o     = pd[Latency-1];
  assign rdata_o_t0  = pt[Latency-1];
  assign rvalid_o_t0 = 1'b0;
  assign gnt_o_t0    = 1'b0;

endmodule

// File: doc/ift_mem_responder.md
# ift_mem_responder

Cycle-accurate, taint-tracking memory responder for the req/gnt/we/strb/addr/wdata/rdata port driven by the picorv32 memory top. It replaces the fixed single-cycle SRAM stub on the data port. It adds:
- programmable grant throttling;
- a fixed-latency response pipeline with explicit `rvalid_o`;
- an out-of-range error flag;
- a bit-level taint shadow of every stored word, used to exercise CPU stall and taint paths.

## Interface
Parameters:
- `Width`, 32, data width in bits; only 32 is supported.
- `Depth`, 1024, number of 32-bit words.
- `BaseAddr`, 32'h8000_0000, byte address mapped to word 0.
- `Latency`, 2, cycles from request acceptance to `rvalid_o`; legal range 1..4.
- `GntGapCycles`, 0, cycles `gnt_o` stays low after each accepted request; legal range 0..7.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `req_i` in 1: request valid.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in 32: byte address.
- `wdata_i` in 32: write data.
- `strb_i` in 4: byte enables.
- `gnt_o` out 1: request accepted this cycle.
- `rvalid_o` out 1: response valid.
- `rdata_o` out 32: read data; 0 for writes.
- `err_o` out 1: response is for an out-of-range address; qualified by `rvalid_o`.
- `req_i_t0`, `we_i_t0` in 1; `addr_i_t0`, `wdata_i_t0` in 32; `strb_i_t0` in 4: input taints.
- `rdata_o_t0` out 32: read data taint.
- `rvalid_o_t0`, `gnt_o_t0` out 1: always 0.

## Operation
Acceptance and address decode:
- A request is accepted in a cycle when `req_i & gnt_o` is 1.
- Word index is `(addr_i - BaseAddr) >> 2`; bits [1:0] are ignored.
- In range means `addr_i - BaseAddr < Depth*4`, evaluated unsigned and modulo 2^32.

Grant throttle (2 states):
- READY: `gnt_o` = 1. An acceptance with `GntGapCycles` > 0 loads the gap counter with `GntGapCycles` and moves to GAP.
- GAP: `gnt_o` = 0. The counter decrements each cycle; at 1 it returns to READY.
- With `GntGapCycles` = 0 the block stays in READY permanently.

Writes:
- Commit at the acceptance edge. Byte b is written iff `strb_i[b]`.
- Out-of-range writes are dropped and return `err_o` = 1.
- Taint of written byte b: `wdata_i_t0[8b+7:8b]` OR'd with a splat of (`|addr_i_t0` | `strb_i_t0[b]` | `we_i_t0` | `req_i_t0`).
- Bytes with `strb_i[b]` = 0 keep both their data and their taint.

Reads:
- Data is sampled from the array at the acceptance edge.
- In range: data = stored word; taint = stored taint OR'd with a 32-bit splat of (`|addr_i_t0` | `we_i_t0` | `req_i_t0`).
- Out of range: `rdata_o` = 0, `err_o` = 1, taint = the same splat.

Response pipeline:
- A shift register `Latency` stages deep; each stage holds {valid, err, data, taint}.
- The pipeline advances every cycle; there is no backpressure from the initiator.
- Responses emerge strictly in acceptance order.

## Timing
- An acceptance at edge T produces `rvalid_o` = 1 for exactly one cycle after edge T+`Latency`-1. With `Latency` = 1 the response appears in the cycle directly after acceptance.
- Throughput is one request every `GntGapCycles`+1 cycles.
- Read-after-write to the same word, accepted on consecutive edges, returns the new data and taint. There is no forwarding hazard because writes commit at acceptance.
- Reset values: `gnt_o` = 1 (state READY, counter 0); `rvalid_o` = 0; `err_o` = 0; `rdata_o` = 0; `rdata_o_t0` = 0.
- Reset asserted mid-operation:
  - all pipeline stages are cleared and in-flight responses are lost;
  - the gap counter is cleared;
  - array contents are retained.
- `req_i` asserted while `gnt_o` = 0: no effect. The initiator must hold the request; the block keeps no record of it.
- Array and taint plane are initialized to 0 at time zero only.

## Configuration
`IFT_MEM_RESPONDER_TAINT_EN`
- Defined: the taint plane is instantiated and all taint rules above apply.
- Undefined:
  - no taint storage is instantiated;
  - `rdata_o_t0` is tied to 0;
  - `*_t0` inputs are ignored;
  - data behaviour and timing are identical to the defined case.

## Test plan
- Reset, then idle: `gnt_o` = 1, `rvalid_o` = 0, `rdata_o` = 0 on the first cycle after `rst_i` drops.
- `Latency` = 2, `GntGapCycles` = 0:
  - write 0xCAFEBABE to 0x8000_0010 with strb 4'hF, then read the same address on the next cycle;
  - required: write ack (`rvalid_o`=1, `rdata_o`=0) follows the write by 2 cycles; the read returns 0xCAFEBABE 2 cycles after it is accepted.
- Byte-strobe merge:
  - write 0x11223344 to 0x8000_0000 with strb 4'hF;
  - then write 0xAABBCCDD with strb 4'b0101;
  - read returns 0x11BB33DD.
- `GntGapCycles` = 3 with `req_i` held high for 8 cycles: `gnt_o` pattern 1,0,0,0,1,0,0,0; exactly 2 responses.
- Out of range, `Depth` = 1024: read 0x8000_1000 gives `rvalid_o` = 1, `err_o` = 1, `rdata_o` = 0. A write to 0x7FFF_FFFC gives `err_o` = 1 and no array change.
- Taint, with the macro defined:
  - write 0x0 to 0x8000_0020 with `wdata_i_t0` = 0x0000_00FF, then read it back: `rdata_o_t0` = 0x0000_00FF;
  - read the same address with `addr_i_t0` = 0x4: `rdata_o_t0` = 0xFFFF_FFFF;
  - assert `rst_i` while a read is in flight: no `rvalid_o` appears for it.
